// File: rtl/risc16_pkg.sv
// Shared RISC-16 definitions for the register scoreboard.
// Register-file geometry and the issue/retire event bundle.
package risc16_pkg;

    localparam int REG_ADDR_WIDTH = 3;
    localparam int REG_CNT        = 2 ** REG_ADDR_WIDTH;

    // Issue and retire buses share one shape: a strobe plus a register.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
    } sb_evt_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one architectural register.
// Ports: clk_i, rst_n_i (sync, active low), clr_i, inc_i, dec_i;
//        nonzero_o, one_o, max_o, underflow_o.
module sb_counter #(
    parameter int W = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o,
    output logic one_o,
    output logic max_o,
    output logic underflow_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !max_o) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i && nonzero_o) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o   = (cnt_q != '0);
    assign one_o       = (cnt_q == W'(1));
    assign max_o       = (&cnt_q);
    // A same-cycle issue to this register covers the retire.
    assign underflow_o = dec_i && !inc_i && !nonzero_o;

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register in-flight write counts,
// ID source busy queries and the ID stall.
// Ports: clk_i, rst_n_i (sync, active low);
//        issue_valid_i/issue_reg_i -> issue_ready_o;
//        retire_valid_i/retire_reg_i; flush_i;
//        id_src_reg_i[1:0] -> src_busy_o, pipeline_ready_o;
//        busy_mask_o (registered state); error_o (sticky).
module reg_scoreboard
    import risc16_pkg::*;
#(
    parameter int REG_CNT       = 2 ** REG_ADDR_WIDTH,
    parameter int CNT_W         = 2,
    parameter bit RETIRE_BYPASS = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]      issue_reg_i,
    output logic                           issue_ready_o,
    input  logic                           retire_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]      retire_reg_i,
    input  logic                           flush_i,
    input  logic [1:0][REG_ADDR_WIDTH-1:0] id_src_reg_i,
    output logic [1:0]                     src_busy_o,
    output logic                           pipeline_ready_o,
    output logic [REG_CNT-1:0]             busy_mask_o,
    output logic                           error_o
);

    sb_evt_t issue;
    sb_evt_t retire;

    assign issue  = '{valid: issue_valid_i,  reg_addr: issue_reg_i};
    assign retire = '{valid: retire_valid_i, reg_addr: retire_reg_i};

    logic [REG_CNT-1:0] nz;
    logic [REG_CNT-1:0] one;
    logic [REG_CNT-1:0] mx;
    logic [REG_CNT-1:0] uf;
    logic [REG_CNT-1:1] inc;
    logic [REG_CNT-1:1] dec;

    // Register 0 is hardwired zero: it never holds a pending write.
    assign nz[0]  = 1'b0;
    assign one[0] = 1'b0;
    assign mx[0]  = 1'b0;
    assign uf[0]  = 1'b0;

    // Comes from registered state only, so inc has no loop back into it.
    assign issue_ready_o = !mx[issue.reg_addr];

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < REG_CNT; r++) begin
            inc[r] = issue.valid && issue_ready_o &&
                     (issue.reg_addr == REG_ADDR_WIDTH'(r));
            dec[r] = retire.valid &&
                     (retire.reg_addr == REG_ADDR_WIDTH'(r));
        end
    end

    for (genvar r = 1; r < REG_CNT; r++) begin : g_cnt
        sb_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .clr_i       (flush_i),
            .inc_i       (inc[r]),
            .dec_i       (dec[r]),
            .nonzero_o   (nz[r]),
            .one_o       (one[r]),
            .max_o       (mx[r]),
            .underflow_o (uf[r])
        );
    end

    // A last pending write retiring now is visible through the
    // write-through regfile, so it no longer blocks the reader.
    for (genvar i = 0; i < 2; i++) begin : g_src
        logic byp;
        assign byp = RETIRE_BYPASS && retire.valid &&
                     (retire.reg_addr == id_src_reg_i[i]) &&
                     one[id_src_reg_i[i]];
        assign src_busy_o[i] = nz[id_src_reg_i[i]] && !byp;
    end

    assign pipeline_ready_o = !src_busy_o[0] && !src_busy_o[1];
    assign busy_mask_o      = nz;

    logic err_q;
    logic err_d;

    // Flush swallows any retire in flight, so no underflow then.
    assign err_d = err_q ||
                   (issue.valid && !issue_ready_o) ||
                   (!flush_i && (|uf));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a
// count-per-register reference model.
module tb_reg_scoreboard;
    import risc16_pkg::*;

    localparam int MAXC = 3;
    localparam int NR   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            iv = 1'b0;
    logic [2:0]      ir = '0;
    logic            rv = 1'b0;
    logic [2:0]      rr = '0;
    logic            fl = 1'b0;
    logic [1:0][2:0] src = '0;
    logic            irdy;
    logic [1:0]      sbusy;
    logic            prdy;
    logic [NR-1:0]   mask;
    logic            err;

    reg_scoreboard #(
        .REG_CNT       (NR),
        .CNT_W         (2),
        .RETIRE_BYPASS (1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .issue_valid_i    (iv),
        .issue_reg_i      (ir),
        .issue_ready_o    (irdy),
        .retire_valid_i   (rv),
        .retire_reg_i     (rr),
        .flush_i          (fl),
        .id_src_reg_i     (src),
        .src_busy_o       (sbusy),
        .pipeline_ready_o (prdy),
        .busy_mask_o      (mask),
        .error_o          (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int m_cnt[NR];
    bit m_err   = 1'b0;
    bit m_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, check before the edge, advance the model.
    task automatic step(input bit rs, input bit i_v, input int i_r,
                        input bit r_v, input int r_r, input bit f,
                        input int s0, input int s1);
        bit          rdy;
        logic [1:0]  bsy;
        logic [NR-1:0] msk;
        int          s;
        rst_n  = !rs;
        iv     = i_v;
        ir     = 3'(i_r);
        rv     = r_v;
        rr     = 3'(r_r);
        fl     = f;
        src[0] = 3'(s0);
        src[1] = 3'(s1);
        @(negedge clk);
        if (m_known) begin
            rdy = (i_r == 0) || (m_cnt[i_r] < MAXC);
            for (int k = 0; k < 2; k++) begin
                s = (k == 0) ? s0 : s1;
                bsy[k] = (s != 0) && (m_cnt[s] > 0) &&
                         !(r_v && r_r == s && m_cnt[s] == 1);
            end
            for (int r = 0; r < NR; r++) msk[r] = (m_cnt[r] > 0);
            check("issue_ready", 32'(irdy), 32'(rdy));
            check("src_busy", 32'(sbusy), 32'(bsy));
            check("pipe_ready", 32'(prdy), 32'(bsy == 2'b00));
            check("busy_mask", 32'(mask), 32'(msk));
            check("error", 32'(err), 32'(m_err));
            if (!rs) begin
                if (i_v && !rdy) m_err = 1'b1;
                if (f) begin
                    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
                end else begin
                    if (i_v && rdy && i_r != 0) m_cnt[i_r]++;
                    if (r_v && r_r != 0) begin
                        if (m_cnt[r_r] > 0) m_cnt[r_r]--;
                        else m_err = 1'b1;
                    end
                end
            end
        end
        if (rs) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pick;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();
        step(0, 0, 0, 0, 0, 0, 3, 5);
        check("rst_mask", 32'(mask), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Issue r3, read it for three cycles, retire on the third.
        step(0, 1, 3, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 1, 3, 0, 3, 0);
        check("r3_clear", 32'(mask[3]), 32'h0);

        // Saturate r2, overflow it, drain it.
        step(0, 1, 2, 0, 0, 0, 2, 0);
        step(0, 1, 2, 0, 0, 0, 2, 0);
        step(0, 1, 2, 0, 0, 0, 2, 0);
        check("r2_busy", 32'(mask[2]), 32'h1);
        step(0, 1, 2, 0, 0, 0, 2, 0);
        check("ovf_err", 32'(err), 32'h1);
        step(0, 0, 0, 1, 2, 0, 2, 0);
        step(0, 0, 0, 1, 2, 0, 2, 0);
        step(0, 0, 0, 1, 2, 0, 2, 0);
        check("r2_drain", 32'(mask[2]), 32'h0);
        do_reset();

        // Issue and retire r6 together while count is 1.
        step(0, 1, 6, 0, 0, 0, 6, 0);
        step(0, 1, 6, 1, 6, 0, 6, 0);
        check("r6_hold", 32'(mask[6]), 32'h1);
        check("r6_noerr", 32'(err), 32'h0);
        step(0, 0, 0, 1, 6, 0, 0, 0);

        // Flush drops everything; a stale retire then underflows.
        step(0, 1, 1, 0, 0, 0, 1, 4);
        step(0, 1, 4, 0, 0, 0, 1, 4);
        step(0, 1, 7, 0, 0, 0, 1, 4);
        step(0, 1, 5, 1, 1, 1, 1, 4);
        check("flush_mask", 32'(mask), 32'h0);
        check("flush_noerr", 32'(err), 32'h0);
        step(0, 0, 0, 1, 4, 0, 1, 4);
        check("stale_err", 32'(err), 32'h1);
        do_reset();

        // Register 0 is inert; reset wins with writes pending.
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("r0_mask", 32'(mask), 32'h0);
        check("r0_err", 32'(err), 32'h0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 1, 2);
        step(1, 1, 4, 1, 1, 1, 1, 2);
        check("mid_rst_mask", 32'(mask), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            bit rs, i_v, r_v, f;
            int i_r, r_r, s0, s1;
            rs  = (c % 250 == 249) || ($urandom_range(299) == 0);
            i_v = $urandom_range(1);
            i_r = $urandom_range(NR - 1);
            r_v = $urandom_range(1);
            r_r = $urandom_range(NR - 1);
            // Mostly retire something actually pending.
            if ($urandom_range(7) != 0) begin
                for (int t = 0; t < 8; t++) begin
                    pick = $urandom_range(NR - 1);
                    if (m_cnt[pick] > 0) begin
                        r_r = pick;
                        break;
                    end
                end
            end
            f  = ($urandom_range(49) == 0);
            s0 = $urandom_range(1) ? r_r : $urandom_range(NR - 1);
            s1 = $urandom_range(NR - 1);
            step(rs, i_v, i_r, r_v, r_r, f, s0, s1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes in the RISC-16 pipeline using one saturating pending-write counter per architectural register.
- Counters increment when a writing instruction leaves ID and decrement when WB commits the write.
- Answers the two ID-stage source-register queries and drives the pipeline stall (pipeline_ready_o).
- Writer-side counterpart to the comparator-based hazard check: state is built from issue/retire events instead of stage-by-stage address compares.

Parameters:
- REG_CNT, 8, number of architectural registers (2**REG_ADDR_WIDTH); register 0 is hardwired zero and never tracked.
- CNT_W, 2, pending counter width; max in-flight writes per register = 2**CNT_W-1 (3 covers EX/MEM/WB).
- RETIRE_BYPASS, 1, 1 = a write retiring this cycle is treated as complete for queries (regfile is write-through).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- issue_valid_i  in  1  instruction with register writeback leaves ID this cycle
- issue_reg_i  in  REG_ADDR_WIDTH  its destination register
- issue_ready_o  out  1  issue_reg_i counter not saturated; issue accepted only when high
- retire_valid_i  in  1  WB stage commits a register write this cycle
- retire_reg_i  in  REG_ADDR_WIDTH  committed register
- flush_i  in  1  whole pipeline behind ID invalidated; clear all pending counts
- id_src_reg_i  in  REG_ADDR_WIDTH x2  ID-stage source register addresses [1:0]
- src_busy_o  out  2  per-source pending-write flag
- pipeline_ready_o  out  1  no source busy; ID may advance
- busy_mask_o  out  REG_CNT  bit r = counter r nonzero (registered state, no bypass)
- error_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_n_i low at a clock edge): all counters 0, error_o 0. Hence src_busy_o=0, pipeline_ready_o=1, issue_ready_o=1, busy_mask_o=0. Reset overrides issue, retire and flush in the same cycle, including mid-operation.
- Register 0: issue, retire and queries addressing 0 are ignored; src_busy for reg 0 is always 0; counter 0 stays 0.
- Counter update per register r, each edge:
  - inc = issue_valid_i & issue_ready_o & issue_reg_i==r
  - dec = retire_valid_i & retire_reg_i==r
  - inc & dec in the same cycle: net 0, no change.
  - inc only: +1. dec only: -1.
- flush_i: all counters go to 0 next cycle.
  - A flush-cycle issue is dropped.
  - A flush-cycle retire is consumed; no error.
  - error_o is not cleared by flush.
- Saturation:
  - issue_ready_o = counter[issue_reg_i] != max; combinational, from registered state.
  - issue_valid_i while issue_ready_o is 0: issue dropped, error_o set.
  - A same-cycle retire of that register does not raise issue_ready_o (conservative).
- Underflow: retire_valid_i to a register whose counter is 0 (and no same-cycle accepted issue to it) sets error_o; counter stays 0.
- Query (combinational, zero-cycle latency from counters):
  - busy_i = id_src_reg_i[i]!=0 & counter[src]!=0.
  - If RETIRE_BYPASS=1, the flag is also masked when retire_valid_i & retire_reg_i==src & counter==1.
  - Same-cycle issue does not affect queries; the issued instruction is older, so the counter reflects it next cycle.
- pipeline_ready_o = ~src_busy_o[0] & ~src_busy_o[1].
- error_o is sticky until reset.
- The outputs are a pure function of state and current inputs; there are no combinational loops through issue_ready_o.

Decomposition:
- risc16 package: REG_ADDR_WIDTH, REG_CNT, and typedef sb_evt_t {logic valid; logic [REG_ADDR_WIDTH-1:0] reg_addr;} used for the issue and retire buses.
- Sub-module sb_counter: one saturating up/down counter with inc/dec/clr inputs and nonzero/max/underflow outputs.
- sb_counter is instantiated for registers 1..REG_CNT-1 via generate.

Test Plan:
- Reset, then query src {3,5} -> src_busy_o=00, pipeline_ready_o=1, busy_mask_o=0, issue_ready_o=1.
- Issue reg 3 at cycle 0, query src[0]=3 at cycles 1..3, retire reg 3 at cycle 3:
  - cycles 1-2: pipeline_ready_o=0.
  - cycle 3 (RETIRE_BYPASS=1): pipeline_ready_o=1.
  - cycle 4: busy_mask_o[3]=0.
- Issue reg 2 three times back-to-back -> busy_mask_o[2]=1, issue_ready_o=0 for issue_reg=2. A fourth issue sets error_o=1 and the count stays 3. Three retires bring busy_mask_o[2] back to 0.
- Issue and retire reg 6 in the same cycle with count 1 -> count stays 1, busy_mask_o[6]=1, no error.
- Issue regs 1,4,7, then flush_i -> busy_mask_o=0 next cycle, pipeline_ready_o=1. A retire of reg 4 after the flush sets error_o=1.
- Issue/retire/query on reg 0 -> no state change, src_busy_o=00. Assert rst_n_i with three pending writes -> all outputs return to reset values next edge.
